if_stage: RTL and testbench

- Instruction Fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory that the debug unit loads.
- Holds the IF/ID pipeline register that supplies the instruction and PC+4 to decode.
- Selects the next PC from four sources:
  - sequential PC+4;
  - branch target, resolved in decode;
  - jump target, computed from the IF/ID instruction;
  - register jump target (rs data from decode).

---
 rtl/if_pkg.sv | 13 +
 rtl/instr_mem.sv | 28 ++
 rtl/if_stage.sv | 115 +++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants for the instruction fetch stage.
package if_pkg;

    // Opcode of the HALT instruction (bits [31:26] of the instruction word).
    localparam logic [5:0]  OPC_HALT = 6'b111111;

    // Instruction word loaded into IF/ID on reset or flush.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Sequential PC increment, in bytes.
    localparam int          PC_INC   = 4;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory.
// Writes are synchronous. Reads are combinational, so a read of a word that
// is being written in the same cycle returns the old contents.
// Contents are never cleared by reset.
module instr_mem #(
    parameter int NB_REG       = 32,
    parameter int NB_IMEM_ADDR = 8
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [NB_IMEM_ADDR-1:0] wr_addr,
    input  logic [NB_REG-1:0]       wr_data,
    input  logic [NB_IMEM_ADDR-1:0] rd_addr,
    output logic [NB_REG-1:0]       rd_data
);

    logic [NB_REG-1:0] mem [2**NB_IMEM_ADDR];

    // Store the debug-unit word on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection, instruction
// memory and the IF/ID pipeline register.
// Optional macro IF_MISALIGN_CHECK_EN: when defined, a register jump whose
// target has non-zero low bits sets the sticky o_pc_misaligned flag.
// Without it the flag is tied low. Target bits [1:0] are dropped either way.
module if_stage
    import if_pkg::*;
#(
    parameter int                NB_REG       = 32,
    parameter int                NB_IMEM_ADDR = 8,
    parameter logic [NB_REG-1:0] RESET_PC     = '0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_dunit_clk_en,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_PCSrc,
    input  logic [NB_REG-1:0]       i_branch_target,
    input  logic                    i_jump,
    input  logic                    i_jump_reg,
    input  logic [NB_REG-1:0]       i_pc_jsel,
    input  logic                    i_dunit_wr_en,
    input  logic [NB_IMEM_ADDR-1:0] i_dunit_wr_addr,
    input  logic [NB_REG-1:0]       i_dunit_wr_data,
    output logic [NB_REG-1:0]       o_inst,
    output logic [NB_REG-1:0]       o_pcplus4,
    output logic [NB_REG-1:0]       o_pc,
    output logic                    o_halt,
    output logic                    o_pc_misaligned
);

    logic [NB_REG-1:0] pc;
    logic [NB_REG-1:0] pc_plus4;
    logic [NB_REG-1:0] next_pc;
    logic [NB_REG-1:0] fetched;
    logic [NB_REG-1:0] jsel_aligned;
    logic              adv;
    logic              fetch_is_halt;

    // Once HALT has been latched the stage stops stepping until reset.
    assign adv           = i_dunit_clk_en & ~o_halt;
    assign pc_plus4      = pc + NB_REG'(PC_INC);
    assign jsel_aligned  = i_pc_jsel & {{(NB_REG-2){1'b1}}, 2'b00};
    assign fetch_is_halt = (fetched[NB_REG-1:NB_REG-6] == OPC_HALT);
    assign o_pc          = pc;

    instr_mem #(
        .NB_REG       (NB_REG),
        .NB_IMEM_ADDR (NB_IMEM_ADDR)
    ) u_instr_mem (
        .clk     (i_clk),
        .wr_en   (i_dunit_wr_en),
        .wr_addr (i_dunit_wr_addr),
        .wr_data (i_dunit_wr_data),
        .rd_addr (pc[NB_IMEM_ADDR+1:2]),
        .rd_data (fetched)
    );

    // Next-PC priority: register jump, jump, taken branch, sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (i_jump_reg) begin
            next_pc = jsel_aligned;
        end else if (i_jump) begin
            next_pc = {o_pcplus4[NB_REG-1:28], o_inst[25:0], 2'b00};
        end else if (i_PCSrc) begin
            next_pc = i_branch_target;
        end
    end

    // PC register; holds on stall, halt or debug freeze.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc <= RESET_PC;
        end else if (adv && !i_stall) begin
            pc <= next_pc;
        end
    end

    // IF/ID register and sticky halt; flush beats stall, and the delay-slot
    // instruction is never squashed by a taken branch or jump.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_inst    <= NB_REG'(NOP_INST);
            o_pcplus4 <= '0;
            o_halt    <= 1'b0;
        end else if (adv) begin
            if (i_flush) begin
                o_inst    <= NB_REG'(NOP_INST);
                o_pcplus4 <= pc_plus4;
            end else if (!i_stall) begin
                o_inst    <= fetched;
                o_pcplus4 <= pc_plus4;
                if (fetch_is_halt) begin
                    o_halt <= 1'b1;
                end
            end
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    // Sticky flag for a register jump that actually redirects to an unaligned target.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pc_misaligned <= 1'b0;
        end else if (adv && !i_stall && i_jump_reg && (i_pc_jsel[1:0] != 2'b00)) begin
            o_pc_misaligned <= 1'b1;
        end
    end
`else
    assign o_pc_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic, checked
// against a reference model through an expected-value queue.
module tb_if_stage;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, stall = 1'b0, flush = 1'b0, pcsrc = 1'b0;
  logic        jump = 1'b0, jump_reg = 1'b0, wr_en = 1'b0;
  logic [31:0] branch_target = '0, pc_jsel = '0, wr_data = '0;
  logic [7:0]  wr_addr = '0;

  logic [31:0] inst, pcplus4, pc;
  logic        halt, misaligned;

  int checks = 0;
  int failures = 0;

  // Expected entry: {pc, inst, pcplus4, halt, misaligned}
  logic [97:0] exp_q[$];

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_inst, m_p4;
  logic        m_halt, m_mis;

  if_stage dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_dunit_clk_en  (en),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_PCSrc         (pcsrc),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_reg      (jump_reg),
    .i_pc_jsel       (pc_jsel),
    .i_dunit_wr_en   (wr_en),
    .i_dunit_wr_addr (wr_addr),
    .i_dunit_wr_data (wr_data),
    .o_inst          (inst),
    .o_pcplus4       (pcplus4),
    .o_pc            (pc),
    .o_halt          (halt),
    .o_pc_misaligned (misaligned)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31:26] = 6'h23;
    return w;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_p4 = 32'h0; m_halt = 1'b0; m_mis = 1'b0;
  endtask

  // Apply the current inputs for one edge to the model, queue the expected
  // post-edge state, then step the clock and return inputs to idle.
  task automatic tick();
    logic [31:0] fetched, n_pc, n_inst, n_p4;
    logic        n_halt, n_mis;
    fetched = m_mem[(m_pc / 4) % DEPTH];
    n_pc = m_pc; n_inst = m_inst; n_p4 = m_p4; n_halt = m_halt; n_mis = m_mis;
    if (en && !m_halt) begin
      if (!stall) begin
        if (jump_reg) n_pc = pc_jsel - (pc_jsel % 4);
        else if (jump) n_pc = (m_p4 & 32'hF000_0000) + ((m_inst % 32'h0400_0000) * 4);
        else if (pcsrc) n_pc = branch_target;
        else n_pc = m_pc + 32'd4;
`ifdef IF_MISALIGN_CHECK_EN
        if (jump_reg && (pc_jsel % 4 != 0)) n_mis = 1'b1;
`endif
      end
      if (flush) begin
        n_inst = 32'h0; n_p4 = m_pc + 32'd4;
      end else if (!stall) begin
        n_inst = fetched; n_p4 = m_pc + 32'd4;
        if ((fetched >> 26) == 32'd63) n_halt = 1'b1;
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
    m_pc = n_pc; m_inst = n_inst; m_p4 = n_p4; m_halt = n_halt; m_mis = n_mis;
    exp_q.push_back({m_pc, m_inst, m_p4, m_halt, m_mis});
    @(posedge clk);
    @(negedge clk);
    en = 0; stall = 0; flush = 0; pcsrc = 0; jump = 0; jump_reg = 0; wr_en = 0;
    branch_target = '0; pc_jsel = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      en = 1;
      tick();
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pcplus4", pcplus4, 32'h0);
    check("rst_halt", {31'd0, halt}, 32'h0);
    check("rst_misaligned", {31'd0, misaligned}, 32'h0);
    #1 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [97:0] e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc", pc, e[97:66]);
      check("inst", inst, e[65:34]);
      check("pcplus4", pcplus4, e[33:2]);
      check("halt", {31'd0, halt}, {31'd0, e[1]});
      check("misaligned", {31'd0, misaligned}, {31'd0, e[0]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007; prog[2] = 32'h0022_1820;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load the whole memory with the debug clock disabled; state must stay at reset.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = 8'(i);
      wr_data = (i < 3) ? prog[i] : rand_word();
      tick();
    end

    // Straight-line fetch of the three program words.
    pulse_reset();
    run(3);

    // Stall with PC=8, then release.
    pulse_reset();
    run(2);
    en = 1; stall = 1; tick();
    en = 1; stall = 1; tick();
    run(1);

    // Taken branch at PC=0x10: delay slot proceeds, then fetch from 0x40.
    pulse_reset();
    run(4);
    en = 1; pcsrc = 1; branch_target = 32'h40; tick();
    run(2);

    // Jump from IF/ID word 0x08000020 with PC+4=8, then misaligned register jump.
    wr_en = 1; wr_addr = 8'd1; wr_data = 32'h0800_0020; tick();
    pulse_reset();
    run(2);
    en = 1; jump = 1; tick();
    en = 1; jump_reg = 1; pc_jsel = 32'h33; tick();
    run(1);

    // HALT at 0xC: freezes with PC=0x10 under any controls, cleared by reset.
    wr_en = 1; wr_addr = 8'd3; wr_data = 32'hFC00_0000; tick();
    pulse_reset();
    run(4);
    for (int i = 0; i < 5; i++) begin
      en = 1; pcsrc = 1; branch_target = 32'h100; flush = 1'($urandom_range(0, 1));
      tick();
    end
    pulse_reset();

    // Flush together with stall, then a disabled edge with a taken branch.
    run(1);
    en = 1; stall = 1; flush = 1; tick();
    run(1);
    en = 0; pcsrc = 1; branch_target = 32'h80; tick();
    run(1);

    // Same-word write and read in one cycle: old word is fetched.
    pulse_reset();
    en = 1; wr_en = 1; wr_addr = 8'd0; wr_data = 32'h1234_5678; tick();
    en = 1; wr_en = 1; wr_addr = 8'd0; wr_data = prog[0]; tick();

    // Randomized traffic with periodic resets.
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 59) pulse_reset();
      en       = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      pcsrc    = ($urandom_range(0, 5) == 0);
      jump     = ($urandom_range(0, 9) == 0);
      jump_reg = ($urandom_range(0, 9) == 0);
      branch_target = $urandom & 32'h0000_03FC;
      pc_jsel  = $urandom;
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 8'($urandom_range(0, DEPTH - 1));
      wr_data  = ($urandom_range(0, 15) == 0) ? 32'hFC00_0000 : rand_word();
      tick();
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
